// File: rtl/rsa_stream_ctrl.sv
// rsa_stream_ctrl
//    Byte-stream front end for the RSA-256 decryption core. It assembles the
//    modulus N, the exponent D and the ciphertext block A from an inbound
//    8-bit valid/ready stream (MSB first), then pulses the core start and waits
//    for the core to finish. The result goes back out as an 8-bit valid/ready
//    stream. N and D persist across blocks until a key reload is requested.
//
// Ports
//    i_clk, i_rst            clock, asynchronous active-high reset
//    i_rx_data/valid, o_rx_ready   inbound byte stream
//    o_tx_data/valid, i_tx_ready   outbound byte stream
//    o_core_start            one-cycle start pulse to the core
//    o_core_a/d/n            ciphertext, exponent, modulus (256 bits each)
//    i_core_result           core result, valid with i_core_finished
//    i_core_finished         core done pulse
//    i_key_reload            reload N and D once the current block is done
//
// Configuration
//    RSA_TX_FULL_BLOCK_EN    undefined: 31 bytes per block, result[247:0]
//                            defined:   32 bytes per block, result[255:0]
//
// state   | meaning
// --------+----------------------------------------------------------
// S_GET_N | shift in 32 bytes of modulus N
// S_GET_D | shift in 32 bytes of exponent D
// S_GET_A | shift in 32 bytes of ciphertext A
// S_START | start pulse to the core
// S_WAIT  | wait for core finish, capture result
// S_SEND  | shift result out, then next block or key reload
module rsa_stream_ctrl (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [7:0]   i_rx_data,
   input  logic         i_rx_valid,
   output logic         o_rx_ready,
   output logic [7:0]   o_tx_data,
   output logic         o_tx_valid,
   input  logic         i_tx_ready,
   output logic         o_core_start,
   output logic [255:0] o_core_a,
   output logic [255:0] o_core_d,
   output logic [255:0] o_core_n,
   input  logic [255:0] i_core_result,
   input  logic         i_core_finished,
   input  logic         i_key_reload
);

   typedef enum logic [2:0] {
      S_GET_N,
      S_GET_D,
      S_GET_A,
      S_START,
      S_WAIT,
      S_SEND
   } state_t;

`ifdef RSA_TX_FULL_BLOCK_EN
   localparam logic [5:0] TX_LAST = 6'd31;
`else
   localparam logic [5:0] TX_LAST = 6'd30;
`endif

   state_t       state;
   state_t       state_nxt;
   logic [5:0]   cnt;
   logic [255:0] n_reg;
   logic [255:0] d_reg;
   logic [255:0] a_reg;
   logic [255:0] tx_reg;
   logic [255:0] tx_load;
   logic         reload_flag;
   logic         rx_ready;
   logic         tx_valid;
   logic         core_start;
   logic         rx_fire;
   logic         tx_fire;
   logic         rx_last;
   logic         tx_last;

   // Handshake flags are registered from the next state, so ready/valid/start
   // change exactly on the edge that enters or leaves their state and are all
   // low while reset is held.
   assign rx_fire = i_rx_valid & rx_ready;
   assign tx_fire = tx_valid & i_tx_ready;
   assign rx_last = rx_fire && (cnt == 6'd31);
   assign tx_last = tx_fire && (cnt == TX_LAST);

`ifdef RSA_TX_FULL_BLOCK_EN
   assign tx_load = i_core_result;
`else
   // Drop the top byte so the first byte out is result[247:240].
   assign tx_load = i_core_result << 8;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_GET_N: if (rx_last) state_nxt = S_GET_D;
         S_GET_D: if (rx_last) state_nxt = S_GET_A;
         S_GET_A: if (rx_last) state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT:  if (i_core_finished) state_nxt = S_SEND;
         S_SEND:  if (tx_last) state_nxt = reload_flag ? S_GET_N : S_GET_A;
         default: state_nxt = S_GET_N;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= S_GET_N;
         cnt         <= 6'd0;
         n_reg       <= '0;
         d_reg       <= '0;
         a_reg       <= '0;
         tx_reg      <= '0;
         reload_flag <= 1'b0;
         rx_ready    <= 1'b0;
         tx_valid    <= 1'b0;
         core_start  <= 1'b0;
      end else begin
         state      <= state_nxt;
         rx_ready   <= (state_nxt inside {S_GET_N, S_GET_D, S_GET_A});
         tx_valid   <= (state_nxt == S_SEND);
         core_start <= (state_nxt == S_START);

         if (state_nxt != state)
            cnt <= 6'd0;
         else if (rx_fire || tx_fire)
            cnt <= cnt + 6'd1;

         if (rx_fire) begin
            case (state)
               S_GET_N: n_reg <= {n_reg[247:0], i_rx_data};
               S_GET_D: d_reg <= {d_reg[247:0], i_rx_data};
               S_GET_A: a_reg <= {a_reg[247:0], i_rx_data};
               default: ;
            endcase
         end

         if ((state == S_WAIT) && i_core_finished)
            tx_reg <= tx_load;
         else if (tx_fire)
            tx_reg <= tx_reg << 8;

         // A reload request arriving on the very cycle the flag is consumed
         // stays pending for the following block.
         if (tx_last && reload_flag)
            reload_flag <= i_key_reload;
         else
            reload_flag <= reload_flag | i_key_reload;
      end
   end

   assign o_rx_ready   = rx_ready;
   assign o_tx_valid   = tx_valid;
   assign o_tx_data    = tx_reg[255:248];
   assign o_core_start = core_start;
   assign o_core_a     = a_reg;
   assign o_core_d     = d_reg;
   assign o_core_n     = n_reg;

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Bench for rsa_stream_ctrl: inbound bytes are driven on the falling edge,
// expected outbound bytes are queued when a block is sent and compared as the
// DUT emits them. A behavioural core answers each start after 100 cycles.
module tb_rsa_stream_ctrl;

`ifdef RSA_TX_FULL_BLOCK_EN
   localparam int NBYTES = 32;
`else
   localparam int NBYTES = 31;
`endif

   logic         clk = 1'b0;
   logic         i_rst;
   logic [7:0]   i_rx_data;
   logic         i_rx_valid;
   logic         o_rx_ready;
   logic [7:0]   o_tx_data;
   logic         o_tx_valid;
   logic         i_tx_ready;
   logic         o_core_start;
   logic [255:0] o_core_a;
   logic [255:0] o_core_d;
   logic [255:0] o_core_n;
   logic [255:0] i_core_result;
   logic         i_core_finished;
   logic         i_key_reload;

   always #5 clk = ~clk;

   rsa_stream_ctrl dut (
      .i_clk           (clk),
      .i_rst           (i_rst),
      .i_rx_data       (i_rx_data),
      .i_rx_valid      (i_rx_valid),
      .o_rx_ready      (o_rx_ready),
      .o_tx_data       (o_tx_data),
      .o_tx_valid      (o_tx_valid),
      .i_tx_ready      (i_tx_ready),
      .o_core_start    (o_core_start),
      .o_core_a        (o_core_a),
      .o_core_d        (o_core_d),
      .o_core_n        (o_core_n),
      .i_core_result   (i_core_result),
      .i_core_finished (i_core_finished),
      .i_key_reload    (i_key_reload)
   );

   int           errors = 0;
   int           checks = 0;
   logic [7:0]   exp_q[$];
   logic [255:0] core_ret;
   logic         tx_mode = 1'b0;
   logic         spurious_req = 1'b0;
   int           blocks_done = 0;
   int           start_count = 0;
   int           core_cnt = 0;
   int           ready_viol = 0;
   int           tx_valid_cycles = 0;
   logic         busy = 1'b0;
   logic         fin_drop = 1'b0;
   logic         fin_spurious = 1'b0;
   logic         chk_ready_next = 1'b0;
   logic         stall_prev = 1'b0;
   logic [7:0]   stall_data;
   logic [7:0]   exp_byte;

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_expected(input logic [255:0] r);
      for (int i = 32 - NBYTES; i < 32; i++)
         exp_q.push_back(r[255 - 8*i -: 8]);
   endtask

   // Drives the first 'count' bytes of w, MSB first; the last byte is pending
   // acceptance on the next rising edge when this returns.
   task automatic send_bytes(input logic [255:0] w, input int count, output int cycles);
      int i;
      i = 0;
      cycles = 0;
      while (i < count && cycles < 1000) begin
         @(negedge clk);
         i_rx_data  = w[255 - 8*i -: 8];
         i_rx_valid = 1'b1;
         if (o_rx_ready) i++;
         cycles++;
      end
      check("rx_bytes_sent", 256'(i), 256'(count));
   endtask

   task automatic idle_rx();
      @(negedge clk);
      i_rx_valid = 1'b0;
   endtask

   task automatic wait_block(input int target);
      int g;
      g = 0;
      while (blocks_done < target && g < 2000) begin
         @(negedge clk);
         g++;
      end
      i_rx_valid = 1'b0;
      check("block_done", 256'(blocks_done), 256'(target));
   endtask

   // Core model, TX sink and TX scoreboard.
   initial begin
      i_tx_ready      = 1'b0;
      i_core_finished = 1'b0;
      i_core_result   = '0;
      forever begin
         @(negedge clk);
         if (chk_ready_next) begin
            check("rx_ready_after_block", 256'(o_rx_ready), 256'(1));
            check("tx_valid_after_block", 256'(o_tx_valid), 256'(0));
            chk_ready_next = 1'b0;
         end
         if (fin_drop) begin
            i_core_finished = 1'b0;
            if (fin_spurious) begin
               check("spurious_tx_valid", 256'(o_tx_valid), 256'(0));
               check("spurious_rx_ready", 256'(o_rx_ready), 256'(1));
            end else begin
               check("finish_to_tx_valid", 256'(o_tx_valid), 256'(1));
            end
            fin_drop = 1'b0;
         end
         if (i_rst) begin
            core_cnt   = 0;
            busy       = 1'b0;
            stall_prev = 1'b0;
         end
         if (o_core_start) begin
            start_count++;
            core_cnt = 100;
            busy     = 1'b1;
         end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               i_core_finished = 1'b1;
               i_core_result   = core_ret;
               fin_drop        = 1'b1;
               fin_spurious    = 1'b0;
            end
         end
         if (spurious_req) begin
            i_core_finished = 1'b1;
            i_core_result   = {8{32'hBADC0FFE}};
            fin_drop        = 1'b1;
            fin_spurious    = 1'b1;
            spurious_req    = 1'b0;
         end
         if (busy && o_rx_ready) ready_viol++;
         if (o_tx_valid && tx_mode) tx_valid_cycles++;
         if (o_tx_valid && stall_prev)
            check("tx_hold", 256'(o_tx_data), 256'(stall_data));
         i_tx_ready = tx_mode ? 1'b1 : ~i_tx_ready;
         if (o_tx_valid && i_tx_ready) begin
            if (exp_q.size() == 0) begin
               check("tx_unexpected", 256'(o_tx_valid), 256'(0));
            end else begin
               exp_byte = exp_q.pop_front();
               check("tx_byte", 256'(o_tx_data), 256'(exp_byte));
               if (exp_q.size() == 0) begin
                  blocks_done++;
                  chk_ready_next = 1'b1;
                  busy           = 1'b0;
               end
            end
            stall_prev = 1'b0;
         end else begin
            stall_prev = o_tx_valid;
            stall_data = o_tx_data;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] key_n, key_d, a1, a2, a3, n2, d2;
      int cyc;
      int g;

      key_n = 256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;
      key_d = 256'hB6ACE0B14720169839B15FD13326CF1A1829BEAFC37BB937BEC8802FBCF46BD9;
      for (int i = 0; i < 32; i++) a1[255 - 8*i -: 8] = 8'(i);
      a2 = {4{64'h0F1E2D3C4B5A6978}};
      a3 = ~a1;
      n2 = {8{32'h13572468}};
      d2 = {8{32'hFEDCBA98}};

      i_rst        = 1'b1;
      i_rx_data    = 8'h00;
      i_rx_valid   = 1'b0;
      i_key_reload = 1'b0;
      core_ret     = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_rx_ready", 256'(o_rx_ready), 256'(0));
      check("rst_tx_valid", 256'(o_tx_valid), 256'(0));
      check("rst_core_start", 256'(o_core_start), 256'(0));
      check("rst_tx_data", 256'(o_tx_data), 256'(0));
      check("rst_core_n", o_core_n, 256'(0));
      check("rst_core_a", o_core_a, 256'(0));
      i_rst = 1'b0;
      @(negedge clk);
      check("rx_ready_after_rst", 256'(o_rx_ready), 256'(1));

      // Reset mid-stream: N loaded, D partially loaded
      send_bytes(key_n, 32, cyc);
      send_bytes(key_d, 10, cyc);
      idle_rx();
      #2 i_rst = 1'b1;
      #1;
      check("midrst_rx_ready", 256'(o_rx_ready), 256'(0));
      check("midrst_core_n", o_core_n, 256'(0));
      check("midrst_core_d", o_core_d, 256'(0));
      @(negedge clk);
      i_rst = 1'b0;
      @(negedge clk);
      check("rx_ready_after_midrst", 256'(o_rx_ready), 256'(1));

      // Key load
      send_bytes(key_n, 32, cyc);
      send_bytes(key_d, 32, cyc);
      idle_rx();
      check("key_n", o_core_n, key_n);
      check("key_d", o_core_d, key_d);

      // Spurious finish in S_GET_A
      spurious_req = 1'b1;
      repeat (4) @(negedge clk);
      check("spurious_tx_valid_late", 256'(o_tx_valid), 256'(0));

      // Block 1: start latency, back-pressure, valid held high throughout
      core_ret = {2{128'h00112233445566778899AABBCCDDEEFF}};
      push_expected(core_ret);
      send_bytes(a1, 32, cyc);
      @(negedge clk);
      i_rx_data = 8'h5A;
      check("start_pulse", 256'(o_core_start), 256'(1));
      check("rx_ready_at_start", 256'(o_rx_ready), 256'(0));
      check("core_a", o_core_a, a1);
      @(negedge clk);
      check("start_single", 256'(o_core_start), 256'(0));
      wait_block(1);
      check("rx_ready_low_in_block1", 256'(ready_viol), 256'(0));
      check("start_count_1", 256'(start_count), 256'(1));

      // Block 2: key reload requested while the core is busy
      core_ret = {8{32'hDEADBEEF}};
      push_expected(core_ret);
      send_bytes(a2, 32, cyc);
      idle_rx();
      g = 0;
      while (core_cnt == 0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      i_key_reload = 1'b1;
      @(negedge clk);
      i_key_reload = 1'b0;
      wait_block(2);
      check("rx_ready_low_in_block2", 256'(ready_viol), 256'(0));
      send_bytes(n2, 32, cyc);
      send_bytes(d2, 32, cyc);
      check("rx_no_bubble_n_to_d", 256'(cyc), 256'(32));
      idle_rx();
      check("reload_core_n", o_core_n, n2);
      check("reload_core_d", o_core_d, d2);
      check("reload_core_a_kept", o_core_a, a2);
      check("start_count_2", 256'(start_count), 256'(2));

      // Block 3: sink always ready, output must be back-to-back
      tx_mode = 1'b1;
      core_ret = {4{64'h0123456789ABCDEF}};
      push_expected(core_ret);
      send_bytes(a3, 32, cyc);
      idle_rx();
      check("core_a_block3", o_core_a, a3);
      wait_block(3);
      check("tx_no_bubble", 256'(tx_valid_cycles), 256'(NBYTES));
      check("start_count_3", 256'(start_count), 256'(3));
      check("key_n_kept", o_core_n, n2);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
